// File: rtl/mes_period_pkg.sv
// Shared types, constants and BCD helper for the period meter.
package mes_period_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DW     = 4;
  localparam int unsigned CW     = DIGITS * DW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_OVF  = 2'd2
  } state_e;

  localparam logic [CW-1:0] BCD_MAX  = 16'h9999;
  localparam logic [CW-1:0] BCD_ZERO = 16'h0000;
  localparam logic [CW-1:0] BCD_ONE  = 16'h0001;

  // Result registers presented to the display side.
  typedef struct packed {
    logic [CW-1:0] per;
    logic          upd;
    logic          ovf;
  } per_res_t;

  // Increment a 4-digit BCD value with 9->0 digit carry.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (c) begin
        if (v[i*DW +: DW] == DW'(9)) begin
          r[i*DW +: DW] = DW'(0);
        end else begin
          r[i*DW +: DW] = v[i*DW +: DW] + DW'(1);
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mes_period_if.sv
// Measurement bus: strobe and signal in, latched period and flags out.
interface mes_period_if;
  import mes_period_pkg::*;

  logic          ce;
  logic          MX;
  logic [CW-1:0] PER;
  logic          upd;
  logic          ovf;

  modport master (output ce, output MX, input PER, input upd, input ovf);
  modport slave  (input ce, input MX, output PER, output upd, output ovf);
endinterface

// File: rtl/mes_period_bcd4_cnt.sv
// Four-digit BCD counter with clear / load-one over increment.
module bcd4_cnt
  import mes_period_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          ld1_i,
  input  logic          inc_i,
  output logic [CW-1:0] q_o,
  output logic          tc_o
);

  logic [CW-1:0] q_q, q_d;
  logic          tc_q;

  // Next count: clear, then load 0001, then increment.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = BCD_ZERO;
    end else if (ld1_i) begin
      q_d = BCD_ONE;
    end else if (inc_i) begin
      q_d = bcd_inc(q_q);
    end
  end

  // Count register; terminal count is registered alongside so it tracks q_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= BCD_ZERO;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= (q_d == BCD_MAX);
    end
  end

  assign q_o  = q_q;
  assign tc_o = tc_q;

endmodule

// File: rtl/mes_period.sv
// Period meter: syncs MX, counts ce strobes between rising edges in BCD.
module mes_period
  import mes_period_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mes_period_if.slave  bus
);

  logic          s0_q, s1_q, s2_q;
  logic          rise;
  state_e        state_q, state_d;
  per_res_t      res_q, res_d;
  logic          cnt_clr, cnt_ld1, cnt_inc;
  logic [CW-1:0] cnt_q;
  logic          cnt_tc;

  // Two-flop synchroniser plus history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s0_q <= bus.MX;
      s1_q <= s0_q;
      s2_q <= s1_q;
    end
  end

  assign rise = s1_q & ~s2_q;

  bcd4_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .ld1_i (cnt_ld1),
    .inc_i (cnt_inc),
    .q_o   (cnt_q),
    .tc_o  (cnt_tc)
  );

  // Next state, counter control and result latching.
  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_d.upd   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_ld1     = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // First edge only opens the window.
        cnt_clr = 1'b1;
        if (rise) begin
          state_d = ST_MEAS;
        end
      end
      ST_MEAS: begin
        if (rise) begin
          // Edge wins over a coincident ce, even at 9999.
          res_d.per = cnt_q;
          res_d.upd = 1'b1;
          res_d.ovf = 1'b0;
          if (bus.ce) begin
            cnt_ld1 = 1'b1;
          end else begin
            cnt_clr = 1'b1;
          end
        end else if (bus.ce) begin
          if (cnt_tc) begin
            state_d   = ST_OVF;
            res_d.per = BCD_MAX;
            res_d.ovf = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_OVF: begin
        // Interrupted period is discarded; restart silently.
        if (rise) begin
          state_d = ST_MEAS;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      res_q   <= '{per: BCD_ZERO, upd: 1'b0, ovf: 1'b0};
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

  assign bus.PER = res_q.per;
  assign bus.upd = res_q.upd;
  assign bus.ovf = res_q.ovf;

endmodule

// File: tb/tb_mes_period.sv
// Directed bench for mes_period: hand-computed periods, overflow and reset cases.
module tb_mes_period;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   upd_seen = 0;
  int   nonbcd = 0;

  always #5 clk = ~clk;

  mes_period_if bus ();

  mes_period dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Count upd pulses and any non-BCD digit seen on PER.
  always @(negedge clk) begin
    if (bus.upd === 1'b1) upd_seen++;
    for (int i = 0; i < 4; i++) begin
      if (bus.PER[i*4 +: 4] > 4'd9) nonbcd++;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic [15:0] exp_per, input logic exp_ovf);
    chk({tag, ".per"}, bus.PER, exp_per);
    chk({tag, ".ovf"}, 16'(bus.ovf), 16'(exp_ovf));
  endtask

  task automatic ce_n(input int n);
    repeat (n) begin
      bus.ce = 1'b1;
      @(negedge clk);
      bus.ce = 1'b0;
      @(negedge clk);
    end
  endtask

  // Rising edge on MX; optional ce in the cycle where the edge is detected.
  task automatic mx_edge(input string tag, input logic ce_rise, input logic exp_upd,
                         input logic [15:0] exp_per, input logic exp_ovf);
    bus.MX = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk({tag, ".upd_early"}, 16'(bus.upd), 16'h0);
    if (ce_rise) bus.ce = 1'b1;
    @(negedge clk);
    bus.ce = 1'b0;
    chk({tag, ".upd"}, 16'(bus.upd), 16'(exp_upd));
    status(tag, exp_per, exp_ovf);
    bus.MX = 1'b0;
    @(negedge clk);
    chk({tag, ".upd_len"}, 16'(bus.upd), 16'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.ce = 1'b0;
    bus.MX = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    status("reset", 16'h0000, 1'b0);
    chk("reset.upd", 16'(bus.upd), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // First edge only opens the window.
    mx_edge("first", 1'b0, 1'b0, 16'h0000, 1'b0);
    ce_n(50);
    status("first50", 16'h0000, 1'b0);
    chk("first50.noupd", 16'(upd_seen), 16'h0);

    // 1234 us periods (50 already counted).
    ce_n(1184);
    mx_edge("p1234a", 1'b0, 1'b1, 16'h1234, 1'b0);
    ce_n(1234);
    mx_edge("p1234b", 1'b0, 1'b1, 16'h1234, 1'b0);

    // Full carry chain.
    ce_n(1000);
    mx_edge("p1000", 1'b0, 1'b1, 16'h1000, 1'b0);
    ce_n(999);
    mx_edge("p0999", 1'b0, 1'b1, 16'h0999, 1'b0);

    // Overflow on the 10000th strobe.
    ce_n(9999);
    status("pre_ovf", 16'h0999, 1'b0);
    ce_n(1);
    status("ovf", 16'h9999, 1'b1);
    mx_edge("after_ovf", 1'b0, 1'b0, 16'h9999, 1'b1);
    ce_n(500);
    mx_edge("p0500", 1'b0, 1'b1, 16'h0500, 1'b0);

    // ce coincident with the edge restarts at 0001.
    ce_n(300);
    mx_edge("p0300ce", 1'b1, 1'b1, 16'h0300, 1'b0);
    ce_n(299);
    mx_edge("p0300", 1'b0, 1'b1, 16'h0300, 1'b0);

    // Edge beats overflow when coincident with the wrapping ce.
    ce_n(9999);
    mx_edge("p9999ce", 1'b1, 1'b1, 16'h9999, 1'b0);
    ce_n(4);
    mx_edge("p0005", 1'b0, 1'b1, 16'h0005, 1'b0);

    // Asynchronous reset mid-measurement.
    ce_n(700);
    rst_n = 1'b0;
    #1;
    status("midrst", 16'h0000, 1'b0);
    chk("midrst.upd", 16'(bus.upd), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mx_edge("rst_first", 1'b0, 1'b0, 16'h0000, 1'b0);
    ce_n(700);
    mx_edge("p0700", 1'b0, 1'b1, 16'h0700, 1'b0);

    chk("upd_total", 16'(upd_seen), 16'd10);
    chk("nonbcd", 16'(nonbcd), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
